pu_queue_payload_mq_fifo: RTL and testbench

Multi-queue payload buffer that stores packed PU queue payload words for `NUM_QUEUES` independent FIFOs in one shared UltraRAM array with a registered read port. Each queue owns a static region of `DEPTH` entries. The block keeps per-queue read/write pointers, occupancy, full/almost-full/empty status, and a per-queue flush. It sits between the PU queue enqueue logic and the PU dispatch arbiter and replaces single-queue 1R1W payload RAMs plus their external pointer logic.

---
 rtl/pu_queue_payload_mq_fifo.sv | 185 ++++++++++++++++++
 tb/tb_pu_queue_payload_mq_fifo.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pu_queue_payload_mq_fifo.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : pu_queue_payload_mq_fifo
// Brief    : NUM_QUEUES independent payload FIFOs sharing one UltraRAM array,
//            with per-queue pointers, occupancy, status and flush.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------

`ifndef PU_QUEUE_PAYLOAD_NBITS
`define PU_QUEUE_PAYLOAD_NBITS 64
`endif

module pu_queue_payload_mq_fifo #(
    parameter int WIDTH        = `PU_QUEUE_PAYLOAD_NBITS,
    parameter int QID_NBITS    = 2,
    parameter int DEPTH_NBITS  = 4,
    parameter int AFULL_THRESH = (1 << DEPTH_NBITS) - 2
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          enq_valid,
    input  logic [QID_NBITS-1:0]                          enq_qid,
    input  logic [WIDTH-1:0]                              enq_data,
    input  logic                                          deq_req,
    input  logic [QID_NBITS-1:0]                          deq_qid,
    input  logic                                          flush_valid,
    input  logic [QID_NBITS-1:0]                          flush_qid,
    output logic                                          deq_valid,
    output logic [QID_NBITS-1:0]                          deq_qid_out,
    output logic [WIDTH-1:0]                              deq_data,
    output logic [(1<<QID_NBITS)-1:0]                     full,
    output logic [(1<<QID_NBITS)-1:0]                     afull,
    output logic [(1<<QID_NBITS)-1:0]                     empty,
    output logic [(1<<QID_NBITS)*(DEPTH_NBITS+1)-1:0]     count,
    output logic                                          enq_drop,
    output logic                                          deq_underrun
);

    localparam int c_NUM_QUEUES = 1 << QID_NBITS;
    localparam int c_DEPTH      = 1 << DEPTH_NBITS;
    localparam int c_CNT_W      = DEPTH_NBITS + 1;
    localparam int c_ADDR_W     = QID_NBITS + DEPTH_NBITS;

    localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(c_DEPTH);
    localparam logic [c_CNT_W-1:0] c_AFULL_CNT = c_CNT_W'(AFULL_THRESH);
    localparam logic               c_AFULL_RST = (AFULL_THRESH == 0);

    (* ram_style = "ultra" *) logic [WIDTH-1:0] r_mem [c_NUM_QUEUES*c_DEPTH];

    logic [DEPTH_NBITS-1:0] r_wptr     [c_NUM_QUEUES];
    logic [DEPTH_NBITS-1:0] r_rptr     [c_NUM_QUEUES];
    logic [c_CNT_W-1:0]     r_count    [c_NUM_QUEUES];
    logic [DEPTH_NBITS-1:0] w_wptr_nxt [c_NUM_QUEUES];
    logic [DEPTH_NBITS-1:0] w_rptr_nxt [c_NUM_QUEUES];
    logic [c_CNT_W-1:0]     w_cnt_nxt  [c_NUM_QUEUES];

    logic [c_NUM_QUEUES-1:0] r_full;
    logic [c_NUM_QUEUES-1:0] r_afull;
    logic [c_NUM_QUEUES-1:0] r_empty;
    logic [c_NUM_QUEUES-1:0] w_full_nxt;
    logic [c_NUM_QUEUES-1:0] w_afull_nxt;
    logic [c_NUM_QUEUES-1:0] w_empty_nxt;
    logic [c_NUM_QUEUES-1:0] w_enq_hit;
    logic [c_NUM_QUEUES-1:0] w_deq_hit;
    logic [c_NUM_QUEUES-1:0] w_flush_hit;

    logic                 r_deq_valid;
    logic [QID_NBITS-1:0] r_deq_qid;
    logic [WIDTH-1:0]     r_deq_data;
    logic                 r_enq_drop;
    logic                 r_deq_underrun;

    logic w_enq_flushed;
    logic w_deq_flushed;
    logic w_enq_ok;
    logic w_deq_ok;
    logic w_enq_drop;
    logic w_deq_underrun;
    logic [c_ADDR_W-1:0] w_waddr;
    logic [c_ADDR_W-1:0] w_raddr;

    // Accept decisions use only start-of-cycle status; a flush silently eats
    // requests aimed at the same queue.
    always_comb begin
        w_enq_flushed  = flush_valid && (flush_qid == enq_qid);
        w_deq_flushed  = flush_valid && (flush_qid == deq_qid);
        w_enq_ok       = enq_valid && !w_enq_flushed && !r_full[enq_qid];
        w_deq_ok       = deq_req   && !w_deq_flushed && !r_empty[deq_qid];
        w_enq_drop     = enq_valid && !w_enq_flushed &&  r_full[enq_qid];
        w_deq_underrun = deq_req   && !w_deq_flushed &&  r_empty[deq_qid];
        w_waddr        = {enq_qid, r_wptr[enq_qid]};
        w_raddr        = {deq_qid, r_rptr[deq_qid]};
    end

    always_comb begin
        w_enq_hit   = '0;
        w_deq_hit   = '0;
        w_flush_hit = '0;
        w_full_nxt  = '0;
        w_afull_nxt = '0;
        w_empty_nxt = '0;
        for (int q = 0; q < c_NUM_QUEUES; q++) begin
            w_enq_hit[q]   = w_enq_ok && (enq_qid == QID_NBITS'(q));
            w_deq_hit[q]   = w_deq_ok && (deq_qid == QID_NBITS'(q));
            w_flush_hit[q] = flush_valid && (flush_qid == QID_NBITS'(q));
            w_wptr_nxt[q]  = r_wptr[q] + DEPTH_NBITS'(w_enq_hit[q]);
            w_rptr_nxt[q]  = r_rptr[q] + DEPTH_NBITS'(w_deq_hit[q]);
            w_cnt_nxt[q]   = r_count[q];
            if (w_enq_hit[q] && !w_deq_hit[q]) begin
                w_cnt_nxt[q] = r_count[q] + c_CNT_W'(1);
            end else if (!w_enq_hit[q] && w_deq_hit[q]) begin
                w_cnt_nxt[q] = r_count[q] - c_CNT_W'(1);
            end
            if (w_flush_hit[q]) begin
                w_wptr_nxt[q] = '0;
                w_rptr_nxt[q] = '0;
                w_cnt_nxt[q]  = '0;
            end
            w_full_nxt[q]  = (w_cnt_nxt[q] == c_DEPTH_CNT);
            w_afull_nxt[q] = (w_cnt_nxt[q] >= c_AFULL_CNT);
            w_empty_nxt[q] = (w_cnt_nxt[q] == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int q = 0; q < c_NUM_QUEUES; q++) begin
                r_wptr[q]  <= '0;
                r_rptr[q]  <= '0;
                r_count[q] <= '0;
            end
            r_full         <= '0;
            r_afull        <= {c_NUM_QUEUES{c_AFULL_RST}};
            r_empty        <= '1;
            r_deq_valid    <= 1'b0;
            r_deq_qid      <= '0;
            r_enq_drop     <= 1'b0;
            r_deq_underrun <= 1'b0;
        end else begin
            for (int q = 0; q < c_NUM_QUEUES; q++) begin
                r_wptr[q]  <= w_wptr_nxt[q];
                r_rptr[q]  <= w_rptr_nxt[q];
                r_count[q] <= w_cnt_nxt[q];
            end
            r_full         <= w_full_nxt;
            r_afull        <= w_afull_nxt;
            r_empty        <= w_empty_nxt;
            r_deq_valid    <= w_deq_ok;
            r_enq_drop     <= w_enq_drop;
            r_deq_underrun <= w_deq_underrun;
            if (w_deq_ok) begin
                r_deq_qid <= deq_qid;
            end
        end
    end

    // Storage has no reset so it maps onto UltraRAM; the pointer reset alone
    // discards queued entries.
    always_ff @(posedge clk) begin
        if (w_enq_ok) begin
            r_mem[w_waddr] <= enq_data;
        end
        if (w_deq_ok) begin
            r_deq_data <= r_mem[w_raddr];
        end
    end

    generate
        for (genvar q = 0; q < c_NUM_QUEUES; q++) begin : g_count
            assign count[q*c_CNT_W +: c_CNT_W] = r_count[q];
        end
    endgenerate

    assign full         = r_full;
    assign afull        = r_afull;
    assign empty        = r_empty;
    assign deq_valid    = r_deq_valid;
    assign deq_qid_out  = r_deq_qid;
    assign deq_data     = r_deq_data;
    assign enq_drop     = r_enq_drop;
    assign deq_underrun = r_deq_underrun;

endmodule

`default_nettype wire

// File: tb/tb_pu_queue_payload_mq_fifo.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_pu_queue_payload_mq_fifo
// Brief    : Directed vector table plus corner sequences for the multi-queue FIFO.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------

module tb_pu_queue_payload_mq_fifo;

    localparam int c_W  = 16;
    localparam int c_CW = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             enq_valid;
    logic [1:0]       enq_qid;
    logic [c_W-1:0]   enq_data;
    logic             deq_req;
    logic [1:0]       deq_qid;
    logic             flush_valid;
    logic [1:0]       flush_qid;
    logic             deq_valid;
    logic [1:0]       deq_qid_out;
    logic [c_W-1:0]   deq_data;
    logic [3:0]       full;
    logic [3:0]       afull;
    logic [3:0]       empty;
    logic [4*c_CW-1:0] count;
    logic             enq_drop;
    logic             deq_underrun;

    int checks = 0;
    int errors = 0;

    pu_queue_payload_mq_fifo #(
        .WIDTH      (c_W),
        .QID_NBITS  (2),
        .DEPTH_NBITS(4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enq_valid   (enq_valid),
        .enq_qid     (enq_qid),
        .enq_data    (enq_data),
        .deq_req     (deq_req),
        .deq_qid     (deq_qid),
        .flush_valid (flush_valid),
        .flush_qid   (flush_qid),
        .deq_valid   (deq_valid),
        .deq_qid_out (deq_qid_out),
        .deq_data    (deq_data),
        .full        (full),
        .afull       (afull),
        .empty       (empty),
        .count       (count),
        .enq_drop    (enq_drop),
        .deq_underrun(deq_underrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ev;
        logic [1:0]  eq;
        logic [15:0] ed;
        logic        dr;
        logic [1:0]  dq;
        logic        fv;
        logic [1:0]  fq;
        logic        xv;
        logic [1:0]  xq;
        logic [15:0] xd;
        logic        xdrop;
        logic        xund;
        logic [1:0]  cq;
        logic [4:0]  xcnt;
    } vec_t;

    vec_t vt[22];

    function automatic vec_t mk(input logic ev, input logic [1:0] eq, input logic [15:0] ed,
                                input logic dr, input logic [1:0] dq,
                                input logic fv, input logic [1:0] fq,
                                input logic xv, input logic [1:0] xq, input logic [15:0] xd,
                                input logic xdrop, input logic xund,
                                input logic [1:0] cq, input logic [4:0] xcnt);
        vec_t v;
        v.ev = ev; v.eq = eq; v.ed = ed; v.dr = dr; v.dq = dq; v.fv = fv; v.fq = fq;
        v.xv = xv; v.xq = xq; v.xd = xd; v.xdrop = xdrop; v.xund = xund;
        v.cq = cq; v.xcnt = xcnt;
        return v;
    endfunction

    function automatic logic [4:0] cnt_of(input int q);
        return count[q*c_CW +: c_CW];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic ev, input logic [1:0] eq, input logic [15:0] ed,
                        input logic dr, input logic [1:0] dq,
                        input logic fv, input logic [1:0] fq);
        enq_valid   = ev;
        enq_qid     = eq;
        enq_data    = ed;
        deq_req     = dr;
        deq_qid     = dq;
        flush_valid = fv;
        flush_qid   = fq;
        @(posedge clk);
        #1;
        enq_valid   = 1'b0;
        deq_req     = 1'b0;
        flush_valid = 1'b0;
    endtask

    task automatic chk_status(input string tag, input int q, input int exp_cnt);
        chk({tag, " count"}, 32'(cnt_of(q)), 32'(exp_cnt));
        chk({tag, " empty"}, 32'(empty[q]), 32'(exp_cnt == 0));
        chk({tag, " full"},  32'(full[q]),  32'(exp_cnt == 16));
        chk({tag, " afull"}, 32'(afull[q]), 32'(exp_cnt >= 14));
    endtask

    task automatic enq(input logic [1:0] q, input logic [15:0] d);
        step(1'b1, q, d, 1'b0, 2'd0, 1'b0, 2'd0);
    endtask

    task automatic deq_expect(input string tag, input logic [1:0] q, input logic [15:0] d);
        step(1'b0, 2'd0, 16'h0, 1'b1, q, 1'b0, 2'd0);
        chk({tag, " valid"}, 32'(deq_valid), 32'd1);
        chk({tag, " qid"},   32'(deq_qid_out), 32'(q));
        chk({tag, " data"},  32'(deq_data), 32'(d));
    endtask

    initial begin
        // 0-8: basic order on q1; 9-10: empty corner on q3;
        // 11-19: flush priority on q1 with q0 bystander; 20-21: flush of q2 leaves q1 alone
        vt[0]  = mk(1, 1, 16'hA000, 0, 0, 0, 0,  0, 0, 16'h0,    0, 0, 1, 1);
        vt[1]  = mk(1, 1, 16'hA001, 0, 0, 0, 0,  0, 0, 16'h0,    0, 0, 1, 2);
        vt[2]  = mk(1, 1, 16'hA002, 0, 0, 0, 0,  0, 0, 16'h0,    0, 0, 1, 3);
        vt[3]  = mk(1, 1, 16'hA003, 0, 0, 0, 0,  0, 0, 16'h0,    0, 0, 1, 4);
        vt[4]  = mk(0, 0, 16'h0,    1, 1, 0, 0,  1, 1, 16'hA000, 0, 0, 1, 3);
        vt[5]  = mk(0, 0, 16'h0,    1, 1, 0, 0,  1, 1, 16'hA001, 0, 0, 1, 2);
        vt[6]  = mk(0, 0, 16'h0,    1, 1, 0, 0,  1, 1, 16'hA002, 0, 0, 1, 1);
        vt[7]  = mk(0, 0, 16'h0,    1, 1, 0, 0,  1, 1, 16'hA003, 0, 0, 1, 0);
        vt[8]  = mk(0, 0, 16'h0,    0, 0, 0, 0,  0, 0, 16'h0,    0, 0, 1, 0);
        vt[9]  = mk(1, 3, 16'h3333, 1, 3, 0, 0,  0, 0, 16'h0,    0, 1, 3, 1);
        vt[10] = mk(0, 0, 16'h0,    1, 3, 0, 0,  1, 3, 16'h3333, 0, 0, 3, 0);
        vt[11] = mk(1, 1, 16'hB000, 0, 0, 0, 0,  0, 0, 16'h0,    0, 0, 1, 1);
        vt[12] = mk(1, 1, 16'hB001, 0, 0, 0, 0,  0, 0, 16'h0,    0, 0, 1, 2);
        vt[13] = mk(1, 1, 16'hB002, 0, 0, 0, 0,  0, 0, 16'h0,    0, 0, 1, 3);
        vt[14] = mk(1, 1, 16'hB003, 0, 0, 0, 0,  0, 0, 16'h0,    0, 0, 1, 4);
        vt[15] = mk(1, 1, 16'hB004, 0, 0, 0, 0,  0, 0, 16'h0,    0, 0, 1, 5);
        vt[16] = mk(1, 0, 16'hC000, 0, 0, 0, 0,  0, 0, 16'h0,    0, 0, 0, 1);
        vt[17] = mk(1, 1, 16'hBEEF, 1, 1, 1, 1,  0, 0, 16'h0,    0, 0, 1, 0);
        vt[18] = mk(0, 0, 16'h0,    1, 0, 0, 0,  1, 0, 16'hC000, 0, 0, 0, 0);
        vt[19] = mk(0, 0, 16'h0,    1, 1, 0, 0,  0, 0, 16'h0,    0, 1, 1, 0);
        vt[20] = mk(1, 1, 16'hD000, 0, 0, 1, 2,  0, 0, 16'h0,    0, 0, 1, 1);
        vt[21] = mk(0, 0, 16'h0,    1, 1, 0, 0,  1, 1, 16'hD000, 0, 0, 1, 0);

        rst = 1'b1;
        enq_valid = 1'b0; enq_qid = '0; enq_data = '0;
        deq_req = 1'b0; deq_qid = '0; flush_valid = 1'b0; flush_qid = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset deq_valid",    32'(deq_valid),    32'd0);
        chk("reset deq_qid_out",  32'(deq_qid_out),  32'd0);
        chk("reset enq_drop",     32'(enq_drop),     32'd0);
        chk("reset deq_underrun", 32'(deq_underrun), 32'd0);
        chk("reset count",        32'(count),        32'd0);
        chk("reset empty",        32'(empty),        32'hF);
        chk("reset full",         32'(full),         32'd0);
        chk("reset afull",        32'(afull),        32'd0);
        rst = 1'b0;

        for (int i = 0; i < 22; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            step(vt[i].ev, vt[i].eq, vt[i].ed, vt[i].dr, vt[i].dq, vt[i].fv, vt[i].fq);
            chk({tag, " deq_valid"}, 32'(deq_valid), 32'(vt[i].xv));
            if (vt[i].xv) begin
                chk({tag, " deq_qid_out"}, 32'(deq_qid_out), 32'(vt[i].xq));
                chk({tag, " deq_data"},    32'(deq_data),    32'(vt[i].xd));
            end
            chk({tag, " enq_drop"},     32'(enq_drop),     32'(vt[i].xdrop));
            chk({tag, " deq_underrun"}, 32'(deq_underrun), 32'(vt[i].xund));
            chk_status(tag, int'(vt[i].cq), int'(vt[i].xcnt));
        end

        // Fill q0 to the top, then overflow once
        for (int i = 0; i < 16; i++) begin
            enq(2'd0, 16'h0F00 + 16'(i));
            chk_status($sformatf("fill%0d", i), 0, i + 1);
        end
        enq(2'd0, 16'hDEAD);
        chk("overflow enq_drop", 32'(enq_drop), 32'd1);
        chk_status("overflow", 0, 16);
        step(1'b0, 2'd0, 16'h0, 1'b0, 2'd0, 1'b0, 2'd0);
        chk("overflow drop pulse width", 32'(enq_drop), 32'd0);
        for (int i = 0; i < 16; i++) begin
            deq_expect($sformatf("drain%0d", i), 2'd0, 16'h0F00 + 16'(i));
            chk_status($sformatf("drain%0d", i), 0, 15 - i);
        end
        step(1'b0, 2'd0, 16'h0, 1'b1, 2'd0, 1'b0, 2'd0);
        chk("drain extra deq_valid", 32'(deq_valid), 32'd0);
        chk("drain extra underrun",  32'(deq_underrun), 32'd1);

        // Sustained enqueue+dequeue on q2 across pointer wrap, bystanders in q0/q1/q3
        enq(2'd0, 16'h1110);
        enq(2'd1, 16'h1111);
        enq(2'd3, 16'h1113);
        for (int i = 0; i < 3; i++) enq(2'd2, 16'h2000 + 16'(i));
        chk_status("wrap prefill", 2, 3);
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 2'd2, 16'h2003 + 16'(i), 1'b1, 2'd2, 1'b0, 2'd0);
            chk($sformatf("wrap%0d valid", i), 32'(deq_valid), 32'd1);
            chk($sformatf("wrap%0d qid", i),   32'(deq_qid_out), 32'd2);
            chk($sformatf("wrap%0d data", i),  32'(deq_data), 32'h2000 + 32'(i));
            chk($sformatf("wrap%0d count", i), 32'(cnt_of(2)), 32'd3);
        end
        for (int i = 40; i < 43; i++) begin
            deq_expect($sformatf("wrap tail%0d", i), 2'd2, 16'h2000 + 16'(i));
        end
        chk_status("wrap end", 2, 0);
        deq_expect("bystander q0", 2'd0, 16'h1110);
        deq_expect("bystander q1", 2'd1, 16'h1111);
        deq_expect("bystander q3", 2'd3, 16'h1113);

        // Reset arriving together with an accepted dequeue
        enq(2'd0, 16'h5555);
        enq(2'd1, 16'h6666);
        rst = 1'b1;
        step(1'b0, 2'd0, 16'h0, 1'b1, 2'd0, 1'b0, 2'd0);
        rst = 1'b0;
        chk("rst inflight deq_valid", 32'(deq_valid), 32'd0);
        chk("rst inflight count",     32'(count), 32'd0);
        chk("rst inflight empty",     32'(empty), 32'hF);
        step(1'b0, 2'd0, 16'h0, 1'b1, 2'd1, 1'b0, 2'd0);
        chk("post rst deq_valid", 32'(deq_valid), 32'd0);
        chk("post rst underrun",  32'(deq_underrun), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
